// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and instruction-memory fetch unit
//
// Purpose:
//   Owns the PC and fetches one 16-bit instruction per PC over a req/ack
//   handshake. The fetched word and its PC are held stable for decode until
//   the branch logic pulses en_pc with the next PC.
//
// Ports:
//   clk          in   1   core clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   run          in   1   core enable; 0 parks the unit in IDLE
//   en_pc        in   1   advance strobe, honoured only in HOLD
//   updated_pc   in   8   next PC from branch logic
//   mem_req      out  1   read request to instruction memory
//   mem_addr     out  8   read address (always current_pc)
//   mem_ack      in   1   mem_rdata valid this cycle
//   mem_rdata    in  16   instruction word from memory
//   current_pc   out  8   PC of the held / in-flight instruction
//   instruction  out 16   registered instruction word
//   instr_valid  out  1   instruction is valid for current_pc
//   fetch_busy   out  1   high while in FETCH
//   fetch_error  out  1   sticky fetch-timeout flag
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined:   FETCH gives up after TIMEOUT_CYCLES cycles without mem_ack,
//              sets sticky fetch_error and blocks further fetches until reset.
//   Undefined: FETCH waits indefinitely; fetch_error is tied 0.

module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        en_pc,
  input  logic [7:0]  updated_pc,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  current_pc,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_nxt;
  logic [15:0] r_instr;
  logic [15:0] w_instr_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_req;
  logic        w_req_nxt;

  // w_timeout: this FETCH cycle is the last one allowed without an ack.
  // w_err_cur: the sticky error that keeps IDLE from starting a new fetch.
  logic        w_timeout;
  logic        w_err_cur;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wait_cnt;
  logic        r_err;

  // Counts completed FETCH cycles without ack; held at zero outside FETCH so
  // every FETCH entry starts from a clean count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 16'd0;
    end else if (r_state != ST_FETCH) begin
      r_wait_cnt <= 16'd0;
    end else if (!mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  // An ack in the final allowed cycle still wins over the timeout.
  assign w_timeout   = (r_state == ST_FETCH) && !mem_ack && (r_wait_cnt == TIMEOUT_LAST);
  assign w_err_cur   = r_err;
  assign fetch_error = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign w_err_cur        = 1'b0;
  assign fetch_error      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 16'h0000;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_req   <= w_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_req_nxt   = r_req;

    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        w_req_nxt   = 1'b0;
        if (run && !w_err_cur) begin
          w_state_nxt = ST_FETCH;
          w_req_nxt   = 1'b1;
        end
      end

      // run is deliberately not looked at here: an issued request always
      // completes so memory never sees a withdrawn read.
      ST_FETCH: begin
        w_req_nxt = 1'b1;
        if (mem_ack) begin
          w_instr_nxt = mem_rdata;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_HOLD;
        end else if (w_timeout) begin
          w_valid_nxt = 1'b0;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (run && en_pc) begin
          w_pc_nxt    = updated_pc;
          w_valid_nxt = 1'b0;
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (!run) begin
          // PC and instruction are kept so a resume re-fetches the same PC.
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_valid_nxt = 1'b0;
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem_req     = r_req;
  assign mem_addr    = r_pc;
  assign current_pc  = r_pc;
  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign fetch_busy  = (r_state == ST_FETCH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        en_pc = 1'b0;
  logic [7:0]  updated_pc = 8'h00;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  current_pc;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_error;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC       (8'h00),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .en_pc       (en_pc),
    .updated_pc  (updated_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .current_pc  (current_pc),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
    .fetch_error (fetch_error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is either outstanding, an instruction is
  // being held, or the unit is parked. Expected outputs change only on
  // clock edges (or reset), computed from the inputs seen at that edge.
  bit          m_fetching;
  bit          m_holding;
  int          m_waited;
  logic [7:0]  e_pc;
  logic [15:0] e_instr;
  bit          e_valid;
  bit          e_req;
  bit          e_err;

  task automatic model_reset();
    m_fetching = 1'b0;
    m_holding  = 1'b0;
    m_waited   = 0;
    e_pc       = 8'h00;
    e_instr    = 16'h0000;
    e_valid    = 1'b0;
    e_req      = 1'b0;
    e_err      = 1'b0;
  endtask

  task automatic start_fetch();
    m_fetching = 1'b1;
    m_holding  = 1'b0;
    m_waited   = 0;
    e_req      = 1'b1;
  endtask

  task automatic model_step();
    if (m_fetching) begin
      if (mem_ack) begin
        e_instr    = mem_rdata;
        e_valid    = 1'b1;
        e_req      = 1'b0;
        m_fetching = 1'b0;
        m_holding  = 1'b1;
      end else begin
        m_waited++;
`ifdef FETCH_TIMEOUT_EN
        if (m_waited == TO) begin
          e_err      = 1'b1;
          e_req      = 1'b0;
          m_fetching = 1'b0;
        end
`endif
      end
    end else if (m_holding) begin
      if (run && en_pc) begin
        e_pc    = updated_pc;
        e_valid = 1'b0;
        start_fetch();
      end else if (!run) begin
        m_holding = 1'b0;
        e_valid   = 1'b0;
      end
    end else if (run && !e_err) begin
      start_fetch();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("mdl_mem_req",     32'(mem_req),     32'(e_req));
        chk("mdl_mem_addr",    32'(mem_addr),    32'(e_pc));
        chk("mdl_current_pc",  32'(current_pc),  32'(e_pc));
        chk("mdl_instruction", 32'(instruction), 32'(e_instr));
        chk("mdl_instr_valid", 32'(instr_valid), 32'(e_valid));
        chk("mdl_fetch_busy",  32'(fetch_busy),  32'(m_fetching));
        chk("mdl_fetch_error", 32'(fetch_error), 32'(e_err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int rst_left;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_current_pc",  32'(current_pc),  32'h00);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_mem_req",     32'(mem_req),     32'h0);
    chk("rst_fetch_error", 32'(fetch_error), 32'h0);
    chk("rst_instruction", 32'(instruction), 32'h0000);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // First fetch, ack in the first FETCH cycle
    run = 1'b1;
    step();
    chk("f1_mem_req",    32'(mem_req),    32'h1);
    chk("f1_mem_addr",   32'(mem_addr),   32'h00);
    chk("f1_fetch_busy", 32'(fetch_busy), 32'h1);
    mem_ack = 1'b1; mem_rdata = 16'hA5C3;
    step();
    chk("f1_instruction", 32'(instruction), 32'hA5C3);
    chk("f1_instr_valid", 32'(instr_valid), 32'h1);
    chk("f1_req_drop",    32'(mem_req),     32'h0);
    mem_ack = 1'b0;

    // Advance to 0x2A, three wait cycles, en_pc noise during FETCH
    en_pc = 1'b1; updated_pc = 8'h2A;
    step();
    chk("adv_current_pc",  32'(current_pc),  32'h2A);
    chk("adv_instr_valid", 32'(instr_valid), 32'h0);
    chk("adv_mem_req",     32'(mem_req),     32'h1);
    chk("adv_mem_addr",    32'(mem_addr),    32'h2A);
    en_pc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_pc = (i == 1); updated_pc = 8'h55;
      step();
      chk("wait_mem_addr", 32'(mem_addr), 32'h2A);
      chk("wait_mem_req",  32'(mem_req),  32'h1);
    end
    en_pc = 1'b1; updated_pc = 8'h66; mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    chk("wait_instruction", 32'(instruction), 32'h1234);
    chk("wait_pc_kept",     32'(current_pc),  32'h2A);
    chk("wait_valid",       32'(instr_valid), 32'h1);
    mem_ack = 1'b0; en_pc = 1'b0;

    // PC wrap 0xFF -> 0x00
    en_pc = 1'b1; updated_pc = 8'hFF;
    step();
    chk("wrap_pc_ff", 32'(current_pc), 32'hFF);
    en_pc = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0; en_pc = 1'b1; updated_pc = 8'h00;
    step();
    chk("wrap_pc_00",   32'(current_pc), 32'h00);
    chk("wrap_addr_00", 32'(mem_addr),   32'h00);
    chk("wrap_req",     32'(mem_req),    32'h1);
    en_pc = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    step();
    chk("wrap_instruction", 32'(instruction), 32'h0F0F);
    mem_ack = 1'b0;

    // run drops in the second FETCH cycle, ack in the third
    en_pc = 1'b1; updated_pc = 8'h77;
    step();
    en_pc = 1'b0;
    step();
    run = 1'b0;
    step();
    chk("rdrop_req_held", 32'(mem_req),    32'h1);
    chk("rdrop_busy",     32'(fetch_busy), 32'h1);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    step();
    chk("rdrop_captured", 32'(instruction), 32'hCAFE);
    chk("rdrop_valid",    32'(instr_valid), 32'h1);
    mem_ack = 1'b0;
    step();
    chk("rdrop_idle_valid", 32'(instr_valid), 32'h0);
    chk("rdrop_idle_req",   32'(mem_req),     32'h0);
    chk("rdrop_idle_instr", 32'(instruction), 32'hCAFE);
    chk("rdrop_idle_pc",    32'(current_pc),  32'h77);
    run = 1'b1;
    step();
    chk("resume_req",  32'(mem_req),  32'h1);
    chk("resume_addr", 32'(mem_addr), 32'h77);
    mem_ack = 1'b1; mem_rdata = 16'hD00D;
    step();
    chk("resume_instr", 32'(instruction), 32'hD00D);
    mem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // No ack: error after TO FETCH cycles, then no new request while run=1
    en_pc = 1'b1; updated_pc = 8'h10;
    step();
    en_pc = 1'b0;
    repeat (TO - 1) step();
    chk("to_not_yet_err", 32'(fetch_error), 32'h0);
    chk("to_not_yet_req", 32'(mem_req),     32'h1);
    step();
    chk("to_error", 32'(fetch_error), 32'h1);
    chk("to_req",   32'(mem_req),     32'h0);
    chk("to_valid", 32'(instr_valid), 32'h0);
    chk("to_busy",  32'(fetch_busy),  32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_stuck_req", 32'(mem_req),     32'h0);
      chk("to_sticky",    32'(fetch_error), 32'h1);
    end
`endif

    // Reset pulse, then reset asserted mid-FETCH with an ack under reset
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    chk("pulse_err_clear", 32'(fetch_error), 32'h0);
    chk("pulse_pc",        32'(current_pc),  32'h00);
    step();
    chk("midrst_fetching", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    reset_n = 1'b0;
    #1;
    chk("midrst_req_async", 32'(mem_req),    32'h0);
    chk("midrst_busy",      32'(fetch_busy), 32'h0);
    step();
    run = 1'b0;
    reset_n = 1'b1;
    mem_ack = 1'b0;
    step();
    chk("midrst_instr", 32'(instruction), 32'h0000);
    chk("midrst_valid", 32'(instr_valid), 32'h0);

    // Randomized traffic checked by the model every cycle
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_n = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        reset_n  = 1'b0;
        rst_left = 2;
      end
      run        = ($urandom_range(0, 7) != 0);
      en_pc      = ($urandom_range(0, 2) == 0);
      updated_pc = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
      mem_ack    = ($urandom_range(0, 3) == 0);
      mem_rdata  = 16'($urandom);
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
